// File: rtl/ysyx_l1_bus_arb_if.sv
// Bus bundle for ysyx_l1_bus_arb: L1I refill port, L1D load/store port and
// the downstream memory port. The slave modport is the arbiter's view; the
// master modport is the view of the surrounding masters and memory.
interface ysyx_l1_bus_arb_if #(
    parameter int XLEN          = 32,
    parameter int L1I_BURST_LEN = 4
);
    localparam int BEAT_W = $clog2(L1I_BURST_LEN);

    // I-side refill port
    logic              i_arvalid;
    logic [XLEN-1:0]   i_araddr;
    logic              i_rready;
    logic [XLEN-1:0]   i_rdata;
    logic              i_rvalid;
    logic              i_rlast;
    logic [BEAT_W-1:0] i_rbeat;

    // D-side load/store port
    logic              d_arvalid;
    logic [XLEN-1:0]   d_araddr;
    logic [7:0]        d_rstrb;
    logic              d_rready;
    logic [XLEN-1:0]   d_rdata;
    logic              d_rvalid;
    logic              d_rlast;
    logic              d_awvalid;
    logic [XLEN-1:0]   d_awaddr;
    logic              d_wvalid;
    logic [XLEN-1:0]   d_wdata;
    logic [7:0]        d_wstrb;
    logic              d_wready;

    // Downstream memory port
    logic              m_arvalid;
    logic [XLEN-1:0]   m_araddr;
    logic [7:0]        m_arlen;
    logic [7:0]        m_rstrb;
    logic              m_arready;
    logic [XLEN-1:0]   m_rdata;
    logic              m_rvalid;
    logic              m_rlast;
    logic              m_awvalid;
    logic [XLEN-1:0]   m_awaddr;
    logic              m_wvalid;
    logic [XLEN-1:0]   m_wdata;
    logic [7:0]        m_wstrb;
    logic              m_wready;

    modport slave (
        input  i_arvalid, i_araddr,
        output i_rready, i_rdata, i_rvalid, i_rlast, i_rbeat,
        input  d_arvalid, d_araddr, d_rstrb,
        output d_rready, d_rdata, d_rvalid, d_rlast,
        input  d_awvalid, d_awaddr, d_wvalid, d_wdata, d_wstrb,
        output d_wready,
        output m_arvalid, m_araddr, m_arlen, m_rstrb,
        input  m_arready, m_rdata, m_rvalid, m_rlast,
        output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb,
        input  m_wready
    );

    modport master (
        output i_arvalid, i_araddr,
        input  i_rready, i_rdata, i_rvalid, i_rlast, i_rbeat,
        output d_arvalid, d_araddr, d_rstrb,
        input  d_rready, d_rdata, d_rvalid, d_rlast,
        output d_awvalid, d_awaddr, d_wvalid, d_wdata, d_wstrb,
        input  d_wready,
        input  m_arvalid, m_araddr, m_arlen, m_rstrb,
        output m_arready, m_rdata, m_rvalid, m_rlast,
        input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb,
        output m_wready
    );
endinterface

// File: rtl/ysyx_l1_bus_arb.sv
// ysyx_l1_bus_arb: two-to-one arbiter between the L1I refill port and the
// L1D load/store port in front of one downstream memory port. One
// transaction is owned at a time; responses are routed only to the owner.
// Optional feature macro: YSYX_BUS_ARB_RR_EN (round-robin I/D read ties;
// otherwise D reads always beat I reads). D writes always win.
module ysyx_l1_bus_arb #(
    parameter int XLEN          = 32,
    parameter int L1I_BURST_LEN = 4
) (
    input logic              clock,
    input logic              reset,
    ysyx_l1_bus_arb_if.slave bus
);
    localparam int         BEAT_W  = $clog2(L1I_BURST_LEN);
    localparam logic [7:0] I_ARLEN = 8'(L1I_BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        I_AR,
        I_R,
        D_AR,
        D_R,
        D_W
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [7:0]        strb_q, strb_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
`ifdef YSYX_BUS_ARB_RR_EN
    logic              last_i_q, last_i_d;
`endif

    logic wr_req;
    logic rd_i_win;
    logic rd_d_win;

    // Arbitration request decode: write first, then the read tie-break rule
    always_comb begin
        wr_req   = bus.d_awvalid & bus.d_wvalid;
`ifdef YSYX_BUS_ARB_RR_EN
        rd_i_win = bus.i_arvalid & (~bus.d_arvalid | ~last_i_q);
`else
        rd_i_win = bus.i_arvalid & ~bus.d_arvalid;
`endif
        rd_d_win = bus.d_arvalid & ~rd_i_win;
    end

    // Next-state, latch updates and all bus outputs
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        beat_d   = beat_q;
`ifdef YSYX_BUS_ARB_RR_EN
        last_i_d = last_i_q;
`endif
        bus.i_rready  = 1'b0;
        bus.i_rdata   = '0;
        bus.i_rvalid  = 1'b0;
        bus.i_rlast   = 1'b0;
        bus.i_rbeat   = '0;
        bus.d_rready  = 1'b0;
        bus.d_rdata   = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_rlast   = 1'b0;
        bus.d_wready  = 1'b0;
        bus.m_arvalid = 1'b0;
        bus.m_araddr  = '0;
        bus.m_arlen   = '0;
        bus.m_rstrb   = '0;
        bus.m_awvalid = 1'b0;
        bus.m_awaddr  = '0;
        bus.m_wvalid  = 1'b0;
        bus.m_wdata   = '0;
        bus.m_wstrb   = '0;

        case (state_q)
            IDLE: begin
                // Grant pulses are combinational, so hold them off while
                // reset is asserted to keep every output low.
                if (!reset) begin
                    if (wr_req) begin
                        state_d = D_W;
                        addr_d  = bus.d_awaddr;
                        wdata_d = bus.d_wdata;
                        strb_d  = bus.d_wstrb;
                    end else if (rd_i_win) begin
                        state_d      = I_AR;
                        addr_d       = bus.i_araddr;
                        strb_d       = 8'hFF;
                        bus.i_rready = 1'b1;
`ifdef YSYX_BUS_ARB_RR_EN
                        last_i_d     = 1'b1;
`endif
                    end else if (rd_d_win) begin
                        state_d      = D_AR;
                        addr_d       = bus.d_araddr;
                        strb_d       = bus.d_rstrb;
                        bus.d_rready = 1'b1;
`ifdef YSYX_BUS_ARB_RR_EN
                        last_i_d     = 1'b0;
`endif
                    end
                end
            end
            I_AR: begin
                bus.m_arvalid = 1'b1;
                bus.m_araddr  = addr_q;
                bus.m_arlen   = I_ARLEN;
                bus.m_rstrb   = strb_q;
                if (bus.m_arready) state_d = I_R;
            end
            D_AR: begin
                bus.m_arvalid = 1'b1;
                bus.m_araddr  = addr_q;
                bus.m_arlen   = '0;
                bus.m_rstrb   = strb_q;
                if (bus.m_arready) state_d = D_R;
            end
            I_R: begin
                bus.i_rdata  = bus.m_rdata;
                bus.i_rvalid = bus.m_rvalid;
                bus.i_rlast  = bus.m_rlast;
                bus.i_rbeat  = beat_q;
                if (bus.m_rvalid) begin
                    if (bus.m_rlast) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            D_R: begin
                bus.d_rdata  = bus.m_rdata;
                bus.d_rvalid = bus.m_rvalid;
                bus.d_rlast  = bus.m_rlast;
                if (bus.m_rvalid && bus.m_rlast) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end
            D_W: begin
                bus.m_awvalid = 1'b1;
                bus.m_awaddr  = addr_q;
                bus.m_wvalid  = 1'b1;
                bus.m_wdata   = wdata_q;
                bus.m_wstrb   = strb_q;
                bus.d_wready  = bus.m_wready;
                if (bus.m_wready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request latches, beat counter and last-grant register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            beat_q   <= '0;
`ifdef YSYX_BUS_ARB_RR_EN
            last_i_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            beat_q   <= beat_d;
`ifdef YSYX_BUS_ARB_RR_EN
            last_i_q <= last_i_d;
`endif
        end
    end
endmodule

// File: doc/ysyx_l1_bus_arb.md
# ysyx_l1_bus_arb

Two-to-one bus arbiter between the L1 instruction cache refill port and the L1 data cache load/store port, in front of the single downstream memory bus port. It grants one transaction at a time and latches the request. It forwards the transaction downstream, routes response beats back to the owner only, and releases the bus on completion. It sits between the l1i/l1d bus masters and the SoC bus bridge.

## Interface
- XLEN, 32, address/data width
- L1I_BURST_LEN, 4, beats per I-side refill (power of two, ≥2); D-side reads are single-beat
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_arvalid  in  1  I-side read request
- i_araddr  in  XLEN  I-side line address
- i_rready  out  1  I-side request-accepted pulse
- i_rdata  out  XLEN  I-side read data
- i_rvalid  out  1  I-side beat valid
- i_rlast  out  1  I-side last beat
- i_rbeat  out  $clog2(L1I_BURST_LEN)  index of current I-side beat
- d_arvalid, d_araddr, d_rstrb[7:0]  in  D-side read request, address, byte strobe
- d_rready  out  1  D-side read accepted pulse
- d_rdata  out  XLEN  D-side read data
- d_rvalid  out  1  D-side beat valid
- d_rlast  out  1  D-side last beat
- d_awvalid, d_awaddr, d_wvalid, d_wdata, d_wstrb[7:0]  in  D-side write request
- d_wready  out  1  D-side write done pulse
- m_arvalid, m_araddr, m_arlen[7:0], m_rstrb[7:0]  out  downstream read request
- m_arready  in  1  downstream read address accepted
- m_rdata  in  XLEN  downstream read data
- m_rvalid  in  1  downstream beat valid
- m_rlast  in  1  downstream last beat
- m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb[7:0]  out  downstream write
- m_wready  in  1  downstream write done

## Operation
- FSM states: IDLE, I_AR, I_R, D_AR, D_R, D_W.
- Arbitration happens in IDLE only. D write (d_awvalid&&d_wvalid) has highest priority. Reads are ordered per Configuration.
- On grant:
  - The owner's address, strobe and data are latched.
  - The owner's accept pulse (i_rready/d_rready) fires in the grant cycle.
  - The upstream request may drop after that cycle.
- I_AR/D_AR: m_arvalid=1 with latched address until m_arready. I uses m_arlen=L1I_BURST_LEN-1 and m_rstrb=8'hFF. D uses m_arlen=0 and m_rstrb=latched d_rstrb. Then move to I_R/D_R.
- I_R/D_R:
  - m_rdata/m_rvalid/m_rlast pass combinationally to the owner only; the other side's rvalid=0.
  - The beat counter increments per beat and drives i_rbeat.
  - m_rvalid&&m_rlast moves the FSM to IDLE and clears the counter.
- D_W: m_awvalid=m_wvalid=1 with latched addr/data/strb until m_wready. d_wready=m_wready, same cycle. Then IDLE.
- m_rvalid outside I_R/D_R, or m_wready outside D_W, is ignored.
- Writes have strict priority; sustained writes can starve reads. Starvation is the LSU's responsibility.

## Timing
- Reset: state IDLE; all outputs 0; latches, counter and last-grant cleared (last-grant = D).
- Request seen in IDLE cycle N: accept pulse in N, m_arvalid/m_awvalid high from N+1.
- Response path is zero-latency and combinational; m_rready is implicitly always 1.
- After completion, one IDLE cycle before the next grant. Minimum spacing is request-to-request 1 arbitration cycle.
- Reset mid-transaction aborts it. Downstream beats arriving after reset are dropped.
- Requests arriving while busy wait. No request is lost while its valid is held.

## Configuration
- YSYX_BUS_ARB_RR_EN defined: I/D read ties go to the side not granted last (round-robin; I wins the first tie after reset).
- YSYX_BUS_ARB_RR_EN undefined: D read always beats I read. Last-grant register removed.

## Test plan
- Single I refill at 0x8000_0040:
  - m_arvalid with m_arlen=3 in cycle N+1.
  - 4 beats forwarded with i_rbeat 0..3; i_rlast on beat 3; IDLE next cycle.
- D load 0x8000_1004 with rstrb 8'h0F: m_arlen=0, m_rstrb=8'h0F; d_rvalid/d_rlast with data 0xDEADBEEF; i_rvalid stays 0.
- Simultaneous d write (0x1000, 0x1234_5678, strb 0x0F), d read and i read in the same cycle:
  - Grant order with RR_EN: write, I, D.
  - Without RR_EN: write, D, I.
- m_arready held low 5 cycles: m_arvalid and address stay stable.
- Reset asserted in the middle of an I burst (beat 1):
  - All outputs 0 immediately.
  - Later m_rvalid beats are not forwarded.
  - A new D read is granted normally.
- Spurious m_rvalid/m_wready in IDLE: no upstream valid/ready asserted; state unchanged.
